// File: rtl/cpu_pkg.sv
// Shared MIPS32 pipeline definitions: load-type encodings used by the
// data-memory read path.
package cpu_pkg;

  localparam logic [2:0] LD_W  = 3'd0;
  localparam logic [2:0] LD_BU = 3'd1;
  localparam logic [2:0] LD_B  = 3'd2;
  localparam logic [2:0] LD_HU = 3'd3;
  localparam logic [2:0] LD_H  = 3'd4;

  // Sign- or zero-extend an 8-bit field to the 32-bit datapath.
  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  // Sign- or zero-extend a 16-bit field to the 32-bit datapath.
  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/dm_ext_core.sv
// Combinational load-data extractor: selects the addressed byte/halfword,
// extends it, and flags misaligned word/halfword loads.
module dm_ext_core
  import cpu_pkg::*;
(
  input  logic [31:0] dm_out,
  input  logic [2:0]  readdm_op,
  input  logic [1:0]  byte_off,
  output logic [31:0] ext_data,
  output logic        adel
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    case (byte_off)
      2'd0:    sel_byte = dm_out[7:0];
      2'd1:    sel_byte = dm_out[15:8];
      2'd2:    sel_byte = dm_out[23:16];
      default: sel_byte = dm_out[31:24];
    endcase
  end

  assign sel_half = byte_off[1] ? dm_out[31:16] : dm_out[15:0];

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; no latch.
    ext_data = dm_out;
    adel     = 1'b0;
    case (readdm_op)
      LD_BU: ext_data = ext_byte(sel_byte, 1'b0);
      LD_B:  ext_data = ext_byte(sel_byte, 1'b1);
      LD_HU: begin
        ext_data = ext_half(sel_half, 1'b0);
        adel     = byte_off[0];
      end
      LD_H: begin
        ext_data = ext_half(sel_half, 1'b1);
        adel     = byte_off[0];
      end
      // LW and the unused encodings 5..7 all behave as a full-word load.
      default: adel = |byte_off;
    endcase
  end

endmodule

// File: rtl/dm_ext.sv
// Load-data extension stage at the M/W boundary: registers the extended
// load result, a valid flag and the AdEL flag with one cycle of latency.
module dm_ext
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_valid,
  input  logic [31:0] dm_out,
  input  logic [2:0]  readdm_op,
  input  logic [31:0] addr,
  output logic [31:0] M_dm_out,
  output logic        M_valid,
  output logic        M_adel
);

  logic [31:0] ext_data;
  logic        adel;

  // Only the byte offset matters; the upper address bits are don't-care here.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:2];

  dm_ext_core u_core (
    .dm_out    (dm_out),
    .readdm_op (readdm_op),
    .byte_off  (addr[1:0]),
    .ext_data  (ext_data),
    .adel      (adel)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      M_dm_out <= '0;
      M_valid  <= 1'b0;
      M_adel   <= 1'b0;
    end else if (ld_valid) begin
      M_dm_out <= adel ? 32'd0 : ext_data;
      M_valid  <= 1'b1;
      M_adel   <= adel;
    end else begin
      // Idle cycle: result data is held, flags drop.
      M_valid  <= 1'b0;
      M_adel   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dm_ext.sv
// Directed self-checking bench for dm_ext: hand-computed results for
// dm_out = 0x8765F0A1 across every load type, alignment and idle cycles.
module tb_dm_ext;
  import cpu_pkg::*;

  localparam logic [31:0] WORD = 32'h8765F0A1;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_valid;
  logic [31:0] dm_out;
  logic [2:0]  readdm_op;
  logic [31:0] addr;
  logic [31:0] M_dm_out;
  logic        M_valid;
  logic        M_adel;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  dm_ext dut (
    .clk       (clk),
    .reset     (reset),
    .ld_valid  (ld_valid),
    .dm_out    (dm_out),
    .readdm_op (readdm_op),
    .addr      (addr),
    .M_dm_out  (M_dm_out),
    .M_valid   (M_valid),
    .M_adel    (M_adel)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] exp_data,
                           input logic exp_valid, input logic exp_adel);
    check({tag, ".data"},  M_dm_out, exp_data);
    check({tag, ".valid"}, {31'd0, M_valid}, {31'd0, exp_valid});
    check({tag, ".adel"},  {31'd0, M_adel},  {31'd0, exp_adel});
  endtask

  // Present inputs 1 time unit after an edge, then return 1 unit after the
  // next edge so outputs are sampled well away from the clock.
  task automatic step(input logic rst, input logic v, input logic [2:0] op,
                      input logic [31:0] a);
    reset     = rst;
    ld_valid  = v;
    readdm_op = op;
    addr      = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    dm_out = WORD;
    #1;

    // Reset wins over a simultaneous load.
    step(1'b1, 1'b1, LD_W, 32'h0000_1000);
    step(1'b1, 1'b1, LD_W, 32'h0000_1000);
    check_out("reset", 32'h0, 1'b0, 1'b0);

    // Words, including an unused encoding treated as LW.
    step(1'b0, 1'b1, LD_W,  32'h0000_1000); check_out("lw_0",   WORD, 1'b1, 1'b0);
    step(1'b0, 1'b1, 3'd6,  32'h0000_1004); check_out("op6_4",  WORD, 1'b1, 1'b0);

    // Bytes.
    step(1'b0, 1'b1, LD_B,  32'h0000_2000); check_out("lb_0",   32'hFFFFFFA1, 1'b1, 1'b0);
    step(1'b0, 1'b1, LD_BU, 32'h0000_2001); check_out("lbu_1",  32'h000000F0, 1'b1, 1'b0);
    step(1'b0, 1'b1, LD_B,  32'h0000_2002); check_out("lb_2",   32'h00000065, 1'b1, 1'b0);
    step(1'b0, 1'b1, LD_B,  32'h0000_2003); check_out("lb_3",   32'hFFFFFF87, 1'b1, 1'b0);
    step(1'b0, 1'b1, LD_BU, 32'h0000_2003); check_out("lbu_3",  32'h00000087, 1'b1, 1'b0);

    // Halfwords.
    step(1'b0, 1'b1, LD_H,  32'h0000_3000); check_out("lh_0",   32'hFFFFF0A1, 1'b1, 1'b0);
    step(1'b0, 1'b1, LD_HU, 32'h0000_3000); check_out("lhu_0",  32'h0000F0A1, 1'b1, 1'b0);
    step(1'b0, 1'b1, LD_H,  32'h0000_3002); check_out("lh_2",   32'hFFFF8765, 1'b1, 1'b0);
    step(1'b0, 1'b1, LD_HU, 32'h0000_3002); check_out("lhu_2",  32'h00008765, 1'b1, 1'b0);

    // Misalignment: data forced to zero, flag raised.
    step(1'b0, 1'b1, LD_W,  32'h0000_4002); check_out("lw_mis2",  32'h0, 1'b1, 1'b1);
    step(1'b0, 1'b1, LD_W,  32'h0000_4001); check_out("lw_mis1",  32'h0, 1'b1, 1'b1);
    step(1'b0, 1'b1, LD_H,  32'h0000_4001); check_out("lh_mis1",  32'h0, 1'b1, 1'b1);
    step(1'b0, 1'b1, LD_HU, 32'h0000_4003); check_out("lhu_mis3", 32'h0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 3'd7,  32'h0000_4003); check_out("op7_mis3", 32'h0, 1'b1, 1'b1);
    step(1'b0, 1'b1, LD_B,  32'h0000_4003); check_out("lb_ok3",   32'hFFFFFF87, 1'b1, 1'b0);

    // Idle cycle holds data and drops both flags.
    step(1'b0, 1'b1, LD_BU, 32'h0000_0001); check_out("lbu_pre",  32'h000000F0, 1'b1, 1'b0);
    step(1'b0, 1'b0, LD_W,  32'h0000_0002); check_out("idle",     32'h000000F0, 1'b0, 1'b0);
    step(1'b0, 1'b0, LD_H,  32'h0000_0001); check_out("idle2",    32'h000000F0, 1'b0, 1'b0);

    // Back-to-back loads, one result per cycle.
    step(1'b0, 1'b1, LD_B,  32'h0000_5000); check_out("b2b_0", 32'hFFFFFFA1, 1'b1, 1'b0);
    step(1'b0, 1'b1, LD_HU, 32'h0000_5002); check_out("b2b_1", 32'h00008765, 1'b1, 1'b0);
    step(1'b0, 1'b1, LD_W,  32'h0000_5000); check_out("b2b_2", WORD,         1'b1, 1'b0);

    // Mid-run reset clears a non-zero result, then normal operation resumes.
    step(1'b1, 1'b1, LD_W,  32'h0000_6000); check_out("reset2", 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b1, LD_HU, 32'h0000_6000); check_out("resume", 32'h0000F0A1, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
